msx_bus_sequencer: RTL and testbench
====================================

// Module: msx_bus_sequencer
// PURPOSE
//  Sequences complete MSX cartridge-slot bus cycles (mem/IO read/write) from a host command port with
//  programmable setup/strobe/hold timing and /WAIT extension. Sits between the SPI command front end and
//  the slot pins, replacing per-bit pin toggling from SPI. Optionally inserts periodic refresh cycles.
// PARAMETERS
//  SETUP_CYC   2    clk cycles address/data/SLTSL valid before strobe (>=1)
//  STROBE_CYC  3    minimum clk cycles MERQ/IORQ + RD/WR asserted (>=1)
//  HOLD_CYC    1    clk cycles address/data held after strobe release (>=1)
//  WAIT_MAX    255  max /WAIT extension cycles before timeout (8-bit counter)
//  RFSH_PERIOD 56   clk cycles between refresh requests (only with MSX_RFSH_EN)
// PORTS
//  clk         in   1   system clock
//  rst         in   1   asynchronous reset, active-high
//  cmd_valid   in   1   host command valid
//  cmd_ready   out  1   sequencer accepts command this cycle
//  cmd_write   in   1   1=write, 0=read
//  cmd_io      in   1   1=IO cycle (IORQ), 0=memory cycle (MERQ+SLTSL)
//  cmd_addr    in   16  bus address
//  cmd_wdata   in   8   write data
//  rsp_valid   out  1   one-cycle pulse: cycle complete
//  rsp_rdata   out  8   read data (valid with rsp_valid, reads only)
//  rsp_timeout out  1   with rsp_valid: /WAIT exceeded WAIT_MAX
//  msx_addr    out  16  slot address bus
//  msx_dout    out  8   slot data out;  msx_doe out 1  data output enable (tri-state outside)
//  msx_din     in   8   slot data in
//  rd_n, wr_n, iorq_n, merq_n, sltsl_n, rfsh_n  out 1 each  slot strobes, active-low
//  wait_n      in   1   slot /WAIT, asynchronous; 2-flop synchronised to wait_s
// BEHAVIOUR
//  Reset (async): state IDLE; all *_n=1; msx_addr=0, msx_dout=0, msx_doe=0; rsp_*=0; counters=0.
//   Reset mid-cycle drops all strobes immediately; no rsp_valid is produced for the aborted cycle.
//  FSM IDLE -> SETUP -> STROBE -> HOLD -> IDLE.
//  IDLE: cmd_ready=1 (see CONFIGURATION). valid&ready in cycle T latches cmd_* ; -> SETUP.
//  SETUP (cycles T+1..T+SETUP_CYC): msx_addr=addr; sltsl_n=0 if mem; msx_doe=1, msx_dout=wdata if write.
//  STROBE: merq_n=0 (mem) or iorq_n=0 (IO); rd_n=0 or wr_n=0. Lasts STROBE_CYC cycles, then extends
//   one cycle per clk while wait_s==0. Extension counter saturating at WAIT_MAX: on reaching it,
//   leave STROBE and set timeout flag. Read data captured from msx_din on the last STROBE cycle.
//  HOLD (HOLD_CYC cycles): strobes=1; addr, sltsl_n, msx_doe/dout unchanged. Last HOLD cycle -> IDLE.
//  rsp_valid pulses in cycle T+1+SETUP_CYC+STROBE_CYC+W+HOLD_CYC (W=extension cycles), first IDLE
//   cycle; cmd_ready is 1 there too, so back-to-back commands are allowed. Default latency W=0: 7.
//  In IDLE: msx_doe=0, sltsl_n=1; msx_addr holds last value. rsp_rdata holds until next rsp.
//  cmd_* changes while not accepted are ignored; latched fields never change mid-cycle.
// CONFIGURATION
//  Macro MSX_RFSH_EN defined: msx_rfsh_timer counts clk, sets sticky rfsh_pending every RFSH_PERIOD.
//   IDLE with rfsh_pending: refresh cycle wins over cmd_valid in same cycle; cmd_ready=0 that cycle.
//   Refresh cycle: same FSM, msx_addr={9'b0,rfsh_addr[6:0]}, rfsh_n=0 SETUP..HOLD, merq_n=0 in STROBE,
//   rd_n=wr_n=sltsl_n=1, no /WAIT extension, no rsp_valid; rfsh_addr+1 (wraps 127->0), pending clears.
//   Pending raised during an active cycle is served at the next IDLE; never preempts.
//  Macro undefined: rfsh_n tied 1, cmd_ready = (state==IDLE), no refresh logic.
// STRUCTURE
//  msx_bus_pkg: state encoding, cycle-type codes (MEM_RD/MEM_WR/IO_RD/IO_WR/RFSH), default timings.
//  Sub-module msx_rfsh_timer (period counter + 7-bit refresh address), instantiated only under macro.
//  wait_n synchroniser inline.
// TESTING
//  Mem read 0x4000, wait_n=1, msx_din=0xA5 -> sltsl_n/merq_n/rd_n sequence, rsp_rdata=0xA5, 7 clk latency.
//  IO write 0x98 data 0x3C, wait_n low 4 cycles in STROBE -> iorq_n/wr_n extended 4 cycles, msx_doe held.
//  wait_n stuck 0 -> strobe released after WAIT_MAX extensions, rsp_valid with rsp_timeout=1.
//  Back-to-back two writes, cmd_valid held -> second accepted in rsp_valid cycle, no idle gap.
//  MSX_RFSH_EN, rfsh_pending and cmd_valid same IDLE cycle -> refresh first (rfsh_n=0, addr 0..127 wrap).
//  rst asserted mid-STROBE -> all *_n=1 asynchronously, no rsp_valid; next command completes normally.

Source files
------------

// File: rtl/msx_bus_pkg.sv
// Shared types for the MSX slot bus sequencer: FSM states, cycle kinds, default timings.
package msx_bus_pkg;

  localparam int unsigned ADDR_W      = 16;
  localparam int unsigned DATA_W      = 8;
  localparam int unsigned CNT_W       = 8;
  localparam int unsigned RFSH_ADDR_W = 7;

  localparam int unsigned DEF_SETUP_CYC   = 2;
  localparam int unsigned DEF_STROBE_CYC  = 3;
  localparam int unsigned DEF_HOLD_CYC    = 1;
  localparam int unsigned DEF_WAIT_MAX    = 255;
  localparam int unsigned DEF_RFSH_PERIOD = 56;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    CYC_MEM_RD = 3'd0,
    CYC_MEM_WR = 3'd1,
    CYC_IO_RD  = 3'd2,
    CYC_IO_WR  = 3'd3,
    CYC_RFSH   = 3'd4
  } cyc_t;

  typedef struct packed {
    cyc_t              kind;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_cmd_t;

  function automatic cyc_t cyc_of(input logic write, input logic io);
    case ({io, write})
      2'b00:   return CYC_MEM_RD;
      2'b01:   return CYC_MEM_WR;
      2'b10:   return CYC_IO_RD;
      default: return CYC_IO_WR;
    endcase
  endfunction

  function automatic logic is_read(input cyc_t k);
    return (k == CYC_MEM_RD) || (k == CYC_IO_RD);
  endfunction

  function automatic logic is_write(input cyc_t k);
    return (k == CYC_MEM_WR) || (k == CYC_IO_WR);
  endfunction

  function automatic logic is_mem(input cyc_t k);
    return (k == CYC_MEM_RD) || (k == CYC_MEM_WR);
  endfunction

  function automatic logic is_io(input cyc_t k);
    return (k == CYC_IO_RD) || (k == CYC_IO_WR);
  endfunction

endpackage

// File: rtl/msx_rfsh_timer.sv
// Refresh period counter with sticky pending flag and 7-bit wrapping refresh address.
module msx_rfsh_timer
  import msx_bus_pkg::*;
#(
  parameter int unsigned PERIOD = DEF_RFSH_PERIOD
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ack,
  output logic                   pending,
  output logic                   pending_nxt_c,
  output logic [RFSH_ADDR_W-1:0] rfsh_addr
);

  localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CW-1:0] cnt;
  logic          tick_c;

  assign tick_c        = (cnt == CW'(PERIOD - 1));
  assign pending_nxt_c = tick_c | (pending & ~ack);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      pending   <= 1'b0;
      rfsh_addr <= '0;
    end else begin
      cnt     <= tick_c ? '0 : cnt + CW'(1);
      pending <= pending_nxt_c;
      if (ack) rfsh_addr <= rfsh_addr + RFSH_ADDR_W'(1);
    end
  end

endmodule

// File: rtl/msx_bus_sequencer.sv
// MSX cartridge-slot bus cycle sequencer with programmable setup/strobe/hold and /WAIT extension.
// Optional refresh cycle insertion is enabled by defining MSX_RFSH_EN.
module msx_bus_sequencer
  import msx_bus_pkg::*;
#(
  parameter int unsigned SETUP_CYC   = DEF_SETUP_CYC,
  parameter int unsigned STROBE_CYC  = DEF_STROBE_CYC,
  parameter int unsigned HOLD_CYC    = DEF_HOLD_CYC,
  parameter int unsigned WAIT_MAX    = DEF_WAIT_MAX,
  parameter int unsigned RFSH_PERIOD = DEF_RFSH_PERIOD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic              cmd_io,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] msx_addr,
  output logic [DATA_W-1:0] msx_dout,
  output logic              msx_doe,
  input  logic [DATA_W-1:0] msx_din,
  output logic              rd_n,
  output logic              wr_n,
  output logic              iorq_n,
  output logic              merq_n,
  output logic              sltsl_n,
  output logic              rfsh_n,
  input  logic              wait_n
);

  if (SETUP_CYC < 1 || SETUP_CYC > 256 || STROBE_CYC < 1 || STROBE_CYC > 256 ||
      HOLD_CYC < 1 || HOLD_CYC > 256 || WAIT_MAX > 255 || RFSH_PERIOD < 2) begin : g_param_check
    $error("msx_bus_sequencer: timing parameter out of range");
  end

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d, ext, ext_d;
  bus_cmd_t          cmd_q, cmd_d;
  logic [DATA_W-1:0] rdata_q, rdata_d, rsp_rdata_d, dout_d;
  logic [ADDR_W-1:0] addr_d;
  logic              timeout_q, timeout_d, rsp_valid_d, rsp_timeout_d, cmd_ready_d;
  logic              doe_d, rd_d, wr_d, iorq_d, merq_d, sltsl_d;
  logic              wait_m, wait_s;
  logic              rfsh_pend_nxt;

`ifdef MSX_RFSH_EN
  logic                   rfsh_pending, rfsh_ack, rfsh_d;
  logic [RFSH_ADDR_W-1:0] rfsh_addr;

  msx_rfsh_timer #(.PERIOD(RFSH_PERIOD)) u_rfsh_timer (
    .clk          (clk),
    .rst          (rst),
    .ack          (rfsh_ack),
    .pending      (rfsh_pending),
    .pending_nxt_c(rfsh_pend_nxt),
    .rfsh_addr    (rfsh_addr)
  );
`else
  assign rfsh_pend_nxt = 1'b0;
  assign rfsh_n        = 1'b1;
`endif

  // /WAIT is asynchronous to clk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_m <= 1'b1;
      wait_s <= 1'b1;
    end else begin
      wait_m <= wait_n;
      wait_s <= wait_m;
    end
  end

  // Next state plus next pin values, so every output leaves a flop
  always_comb begin
    state_d       = state;
    cnt_d         = cnt;
    ext_d         = ext;
    cmd_d         = cmd_q;
    rdata_d       = rdata_q;
    timeout_d     = timeout_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata;
    rsp_timeout_d = 1'b0;
`ifdef MSX_RFSH_EN
    rfsh_ack      = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        cnt_d = '0;
        ext_d = '0;
`ifdef MSX_RFSH_EN
        if (rfsh_pending) begin
          cmd_d    = '{kind: CYC_RFSH, addr: ADDR_W'(rfsh_addr), wdata: '0};
          rfsh_ack = 1'b1;
          state_d  = ST_SETUP;
        end else
`endif
        if (cmd_valid) begin
          cmd_d   = '{kind: cyc_of(cmd_write, cmd_io), addr: cmd_addr, wdata: cmd_wdata};
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt == CNT_W'(SETUP_CYC - 1)) begin
          cnt_d   = '0;
          state_d = ST_STROBE;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      ST_STROBE: begin
        if (cnt != CNT_W'(STROBE_CYC - 1)) begin
          cnt_d = cnt + CNT_W'(1);
        end else if (wait_s || cmd_q.kind == CYC_RFSH || ext == CNT_W'(WAIT_MAX)) begin
          cnt_d     = '0;
          rdata_d   = msx_din;
          timeout_d = !wait_s && cmd_q.kind != CYC_RFSH;
          state_d   = ST_HOLD;
        end else begin
          ext_d = ext + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (cnt == CNT_W'(HOLD_CYC - 1)) begin
          state_d       = ST_IDLE;
          rsp_valid_d   = cmd_q.kind != CYC_RFSH;
          rsp_timeout_d = timeout_q;
          if (is_read(cmd_q.kind)) rsp_rdata_d = rdata_q;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    addr_d  = msx_addr;
    dout_d  = msx_dout;
    doe_d   = 1'b0;
    sltsl_d = 1'b1;
    rd_d    = 1'b1;
    wr_d    = 1'b1;
    iorq_d  = 1'b1;
    merq_d  = 1'b1;
`ifdef MSX_RFSH_EN
    rfsh_d  = 1'b1;
`endif
    if (state_d != ST_IDLE) begin
      addr_d  = cmd_d.addr;
      doe_d   = is_write(cmd_d.kind);
      sltsl_d = !is_mem(cmd_d.kind);
      if (is_write(cmd_d.kind)) dout_d = cmd_d.wdata;
`ifdef MSX_RFSH_EN
      rfsh_d  = cmd_d.kind != CYC_RFSH;
`endif
      if (state_d == ST_STROBE) begin
        merq_d = !(is_mem(cmd_d.kind) || cmd_d.kind == CYC_RFSH);
        iorq_d = !is_io(cmd_d.kind);
        rd_d   = !is_read(cmd_d.kind);
        wr_d   = !is_write(cmd_d.kind);
      end
    end
    cmd_ready_d = (state_d == ST_IDLE) && !rfsh_pend_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      ext         <= '0;
      cmd_q       <= '{kind: CYC_MEM_RD, addr: '0, wdata: '0};
      rdata_q     <= '0;
      timeout_q   <= 1'b0;
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_timeout <= 1'b0;
      msx_addr    <= '0;
      msx_dout    <= '0;
      msx_doe     <= 1'b0;
      rd_n        <= 1'b1;
      wr_n        <= 1'b1;
      iorq_n      <= 1'b1;
      merq_n      <= 1'b1;
      sltsl_n     <= 1'b1;
`ifdef MSX_RFSH_EN
      rfsh_n      <= 1'b1;
`endif
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      ext         <= ext_d;
      cmd_q       <= cmd_d;
      rdata_q     <= rdata_d;
      timeout_q   <= timeout_d;
      cmd_ready   <= cmd_ready_d;
      rsp_valid   <= rsp_valid_d;
      rsp_rdata   <= rsp_rdata_d;
      rsp_timeout <= rsp_timeout_d;
      msx_addr    <= addr_d;
      msx_dout    <= dout_d;
      msx_doe     <= doe_d;
      rd_n        <= rd_d;
      wr_n        <= wr_d;
      iorq_n      <= iorq_d;
      merq_n      <= merq_d;
      sltsl_n     <= sltsl_d;
`ifdef MSX_RFSH_EN
      rfsh_n      <= rfsh_d;
`endif
    end
  end

endmodule

// File: tb/tb_msx_bus_sequencer.sv
// Scoreboard bench for msx_bus_sequencer (default build, refresh disabled).
module tb_msx_bus_sequencer;

  localparam int SETUP = 2, STROBE = 3, HOLD = 1, WMAX = 255;

  logic        clk = 1'b0, rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0, cmd_io = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [7:0]  cmd_wdata = '0, msx_din = '0;
  logic        wait_n = 1'b1;
  logic        cmd_ready, rsp_valid, rsp_timeout, msx_doe;
  logic [7:0]  rsp_rdata, msx_dout;
  logic [15:0] msx_addr;
  logic        rd_n, wr_n, iorq_n, merq_n, sltsl_n, rfsh_n;

  msx_bus_sequencer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_io(cmd_io), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
    .msx_addr(msx_addr), .msx_dout(msx_dout), .msx_doe(msx_doe), .msx_din(msx_din),
    .rd_n(rd_n), .wr_n(wr_n), .iorq_n(iorq_n), .merq_n(merq_n), .sltsl_n(sltsl_n),
    .rfsh_n(rfsh_n), .wait_n(wait_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  dout;
    logic        doe, sltsl, merq, iorq, rd, wr;
  } pins_t;

  typedef struct {
    int         cyc;
    logic       rd;
    logic [7:0] rdata;
    logic       to;
  } rsp_t;

  pins_t exp_pins[int];
  bit    wait_low[int];
  rsp_t  exp_q[$];
  int    cyc = 0;
  int    n_tests = 0, n_fail = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) wait_n = !wait_low.exists(cyc);

  // Monitor: pin-level expectations per cycle and response scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (exp_pins.exists(cyc)) begin
        pins_t p;
        p = exp_pins[cyc];
        chk("addr", msx_addr, p.addr);
        chk("doe", msx_doe, p.doe);
        if (p.doe) chk("dout", msx_dout, p.dout);
        chk("sltsl_n", sltsl_n, p.sltsl);
        chk("merq_n", merq_n, p.merq);
        chk("iorq_n", iorq_n, p.iorq);
        chk("rd_n", rd_n, p.rd);
        chk("wr_n", wr_n, p.wr);
        chk("busy_cmd_ready", cmd_ready, 0);
        exp_pins.delete(cyc);
      end else begin
        chk("idle_strobes", {merq_n, iorq_n, rd_n, wr_n, sltsl_n}, 5'b11111);
        chk("idle_doe", msx_doe, 0);
        chk("idle_cmd_ready", cmd_ready, 1);
      end
      chk("rfsh_n", rfsh_n, 1);
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        rsp_t r;
        r = exp_q.pop_front();
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_timeout", rsp_timeout, r.to);
        if (r.rd) chk("rsp_rdata", rsp_rdata, r.rdata);
      end else begin
        chk("rsp_valid_quiet", rsp_valid, 0);
      end
    end
  end

  // Issues one command from a negedge; returns at the negedge after acceptance (cycle T+1)
  task automatic do_cmd(input logic w, input logic io, input logic [15:0] a, input logic [7:0] wd,
                        input logic [7:0] din, input int k, input int gap);
    int    t, wx, nl, b;
    pins_t p;
    repeat (gap) begin
      cmd_valid = 1'b0;
      cmd_addr  = 16'($urandom);
      @(negedge clk);
    end
    cmd_valid = 1'b1; cmd_write = w; cmd_io = io; cmd_addr = a; cmd_wdata = wd;
    b = 0;
    while (!cmd_ready) begin
      @(negedge clk);
      b++;
      if (b > 2000) begin
        chk("accept_timeout", 0, 1);
        cmd_valid = 1'b0;
        return;
      end
    end
    t  = cyc;
    wx = (k > WMAX) ? WMAX : k;
    nl = (k > WMAX) ? WMAX + 1 : k;
    for (int i = 0; i < nl; i++) wait_low[t + 3 + i] = 1'b1;
    p = '{addr: a, dout: wd, doe: w, sltsl: io, merq: 1'b1, iorq: 1'b1, rd: 1'b1, wr: 1'b1};
    for (int i = 1; i <= SETUP; i++) exp_pins[t + i] = p;
    p.merq = io; p.iorq = !io; p.rd = w; p.wr = !w;
    for (int i = 0; i < STROBE + wx; i++) exp_pins[t + 1 + SETUP + i] = p;
    p.merq = 1'b1; p.iorq = 1'b1; p.rd = 1'b1; p.wr = 1'b1;
    for (int i = 0; i < HOLD; i++) exp_pins[t + 1 + SETUP + STROBE + wx + i] = p;
    exp_q.push_back('{cyc: t + 1 + SETUP + STROBE + wx + HOLD, rd: !w, rdata: din, to: (k > WMAX)});
    @(negedge clk);
    msx_din   = din;
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_io    = 1'($urandom);
    cmd_addr  = 16'($urandom);
    cmd_wdata = 8'($urandom);
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (exp_q.size() > 0 && b < 2000) begin
      @(negedge clk);
      b++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    @(posedge clk);
    #1;
    chk("rst_strobes", {rd_n, wr_n, iorq_n, merq_n, sltsl_n, rfsh_n}, 6'b111111);
    chk("rst_addr", msx_addr, 0);
    chk("rst_dout", msx_dout, 0);
    chk("rst_doe", msx_doe, 0);
    chk("rst_rsp", {rsp_valid, rsp_timeout, rsp_rdata}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Mem read 0x4000, no wait
    do_cmd(1'b0, 1'b0, 16'h4000, 8'h00, 8'hA5, 0, 0);
    // IO write 0x98 with 4 wait extensions
    do_cmd(1'b1, 1'b1, 16'h0098, 8'h3C, 8'h00, 4, 2);
    // /WAIT stuck low: timeout
    do_cmd(1'b0, 1'b1, 16'h00A8, 8'h00, 8'h5A, WMAX + 1, 1);
    // Exactly WAIT_MAX extensions without timeout
    do_cmd(1'b0, 1'b0, 16'h8001, 8'h00, 8'hC3, WMAX, 1);
    // Back-to-back writes with cmd_valid held
    do_cmd(1'b1, 1'b0, 16'hC000, 8'h11, 8'h00, 0, 1);
    do_cmd(1'b1, 1'b0, 16'hC001, 8'h22, 8'h00, 0, 0);
    do_cmd(1'b0, 1'b1, 16'h0099, 8'h00, 8'h77, 0, 0);

    for (int n = 0; n < 40; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      do_cmd(1'($urandom), 1'($urandom), 16'($urandom), 8'($urandom), 8'($urandom),
             (r < 6) ? 0 : r - 5, int'($urandom_range(0, 2)));
    end
    drain();

    // Reset in the middle of STROBE
    do_cmd(1'b1, 1'b0, 16'h4321, 8'h99, 8'h00, 0, 1);
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_strobes", {rd_n, wr_n, iorq_n, merq_n, sltsl_n, rfsh_n}, 6'b111111);
    chk("midrst_doe", msx_doe, 0);
    chk("midrst_rsp", rsp_valid, 0);
    exp_pins.delete();
    exp_q.delete();
    wait_low.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    do_cmd(1'b0, 1'b0, 16'h1234, 8'h00, 8'h6E, 2, 0);
    drain();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
